// File: rtl/enc_snd_32_pkg.sv
// Shared types and constants for the encoder-delta return path.
// State encoding, counter width default and packing positions of the 32-bit word.
package enc_snd_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int R_LSB     = 0;
  localparam int L_LSB     = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LATCH   = 2'd1,
    SEND    = 2'd2,
    SEND_TS = 2'd3
  } state_e;

  // Gray phase {A,B} -> position 0..3 along the forward sequence 00,01,11,10
  function automatic logic [1:0] gray_pos(input logic a, input logic b);
    return {a, a ^ b};
  endfunction

endpackage

// File: rtl/enc_snd_32_if.sv
// Write side of the 32-bit FPGA->host FIFO: data, write enable and full flag.
// The producer (master) never asserts snd_en_32 while data_full_32 is high.
interface enc_snd_32_if;

  logic [31:0] snd_data_32;
  logic        snd_en_32;
  logic        data_full_32;

  modport master (
    output snd_data_32,
    output snd_en_32,
    input  data_full_32
  );

  modport slave (
    input  snd_data_32,
    input  snd_en_32,
    output data_full_32
  );

endinterface

// File: rtl/enc_snd_32_quad_dec.sv
// One wheel: 2-flop synchronizer, x4 quadrature decode and a wrapping signed delta counter.
// next_cnt includes this cycle's step; clr loads 0 so a step on the clear cycle lands in next_cnt.
module quad_dec
  import enc_snd_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_32,
  input  logic             a,
  input  logic             b,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] next_cnt
);

  logic             a_s1_q, a_s1_d, a_s2_q, a_s2_d;
  logic             b_s1_q, b_s1_d, b_s2_q, b_s2_d;
  logic [1:0]       ab_prev_q, ab_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       pos_diff;
  logic [CNT_W-1:0] inc;

  always_comb begin
    a_s1_d    = a;
    b_s1_d    = b;
    a_s2_d    = a_s1_q;
    b_s2_d    = b_s1_q;
    ab_prev_d = {a_s2_q, b_s2_q};

    // Diff of 2 means both phases moved: illegal, contributes nothing
    pos_diff  = gray_pos(a_s2_q, b_s2_q) - gray_pos(ab_prev_q[1], ab_prev_q[0]);
    inc       = '0;
    if (pos_diff == 2'd1) begin
      inc = CNT_W'(1);
    end else if (pos_diff == 2'd3) begin
      inc = '1;
    end

    next_cnt = cnt_q + inc;
    cnt_d    = clr ? '0 : next_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst_32) begin
      a_s1_q    <= 1'b0;
      a_s2_q    <= 1'b0;
      b_s1_q    <= 1'b0;
      b_s2_q    <= 1'b0;
      ab_prev_q <= 2'b00;
      cnt_q     <= '0;
    end else begin
      a_s1_q    <= a_s1_d;
      a_s2_q    <= a_s2_d;
      b_s1_q    <= b_s1_d;
      b_s2_q    <= b_s2_d;
      ab_prev_q <= ab_prev_d;
      cnt_q     <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/enc_snd_32.sv
// Periodic packer of right/left encoder deltas into FIFO words; tick->write >= 2 cycles, holds in SEND while full.
// Late ticks are dropped (counted) and motion accumulates; SND_TIMESTAMP_EN appends a cycle-count word.
module enc_snd_32
  import enc_snd_pkg::*;
#(
  parameter int SAMPLE_DIV = 100000,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst_32,
  input  logic         snd_enable,
  input  logic         enc_a_r,
  input  logic         enc_b_r,
  input  logic         enc_a_l,
  input  logic         enc_b_l,
  enc_snd_32_if.master snd_if,
  output logic [7:0]   drop_cnt
);

  localparam int              TMR_W    = $clog2(SAMPLE_DIV);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SAMPLE_DIV - 1);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [31:0]      data_q, data_d;
  logic [7:0]       drop_q, drop_d;
  logic             tick, clr, snd_en;
  logic [CNT_W-1:0] next_r, next_l;
  logic [CNT_W-1:0] unused_cnt_r, unused_cnt_l;

`ifdef SND_TIMESTAMP_EN
  logic [31:0]      cyc_q, cyc_d;
  logic [31:0]      ts_q, ts_d;
`endif

  quad_dec #(.CNT_W(CNT_W)) u_dec_r (
    .clk      (clk),
    .rst_32   (rst_32),
    .a        (enc_a_r),
    .b        (enc_b_r),
    .clr      (clr),
    .cnt      (unused_cnt_r),
    .next_cnt (next_r)
  );

  quad_dec #(.CNT_W(CNT_W)) u_dec_l (
    .clk      (clk),
    .rst_32   (rst_32),
    .a        (enc_a_l),
    .b        (enc_b_l),
    .clr      (clr),
    .cnt      (unused_cnt_l),
    .next_cnt (next_l)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    drop_d  = drop_q;
    clr     = 1'b0;
    snd_en  = 1'b0;
`ifdef SND_TIMESTAMP_EN
    cyc_d   = cyc_q + 32'd1;
    ts_d    = ts_q;
`endif

    tick    = snd_enable && (timer_q == TMR_LAST);
    timer_d = (!snd_enable || tick) ? '0 : timer_q + TMR_W'(1);

    if (tick && (state_q != IDLE) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (tick) state_d = LATCH;
      end
      LATCH: begin
        data_d[R_LSB +: CNT_W] = next_r;
        data_d[L_LSB +: CNT_W] = next_l;
        clr     = 1'b1;
        state_d = SEND;
`ifdef SND_TIMESTAMP_EN
        ts_d    = cyc_q;
`endif
      end
      SEND: begin
        if (!snd_if.data_full_32) begin
          snd_en = 1'b1;
`ifdef SND_TIMESTAMP_EN
          // Reuse the output register for the timestamp so the data path stays one flop
          data_d  = ts_q;
          state_d = SEND_TS;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef SND_TIMESTAMP_EN
      SEND_TS: begin
        if (!snd_if.data_full_32) begin
          snd_en  = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_32) begin
      state_q <= IDLE;
      timer_q <= '0;
      data_q  <= '0;
      drop_q  <= '0;
`ifdef SND_TIMESTAMP_EN
      cyc_q   <= '0;
      ts_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
`ifdef SND_TIMESTAMP_EN
      cyc_q   <= cyc_d;
      ts_q    <= ts_d;
`endif
    end
  end

  assign snd_if.snd_data_32 = data_q;
  assign snd_if.snd_en_32   = snd_en;
  assign drop_cnt           = drop_q;

endmodule
